psg_write_sched: RTL and testbench
==================================

PSG_WRITE_SCHED -- requirements
Module: psg_write_sched

Interface
REQ-001 The block SHALL have one clock and one reset: the reset SHALL be synchronous and active-low.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- HOLD_CYC, 32, number of clk cycles the block waits after each PSG write (1..255).
- LOCK_TO, 64, number of clk cycles the block waits for the second byte of a frequency pair before it releases the lock (1..255).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- cpu_we, in, 1, one-cycle CPU write strobe.
- cpu_data, in, 8, CPU write byte.
- cpu_full, out, 1, CPU FIFO is full; CPU must wait.
- cpu_ovf, out, 1, sticky flag: a CPU write was dropped.
- seq_valid, in, 1, sequencer has a byte to send.
- seq_data, in, 8, sequencer byte.
- seq_ready, out, 1, sequencer byte accepted this cycle.
- mute_req, in, 1, level input; a rising edge requests a mute of all channels.
- psg_ce, out, 1, PSG write enable.
- psg_we, out, 1, PSG write enable.
- psg_data, out, 8, PSG write byte.
- busy, out, 1, block is not in IDLE.

Function
REQ-004 The CPU port SHALL feed a 4-entry FIFO.
- A push SHALL occur on cpu_we when the FIFO is not full.
- cpu_we while full SHALL drop the byte and set cpu_ovf.
- Full SHALL be evaluated before a same-cycle pop.
REQ-005 cpu_full SHALL be registered and SHALL equal (count==4).
REQ-006 The FSM SHALL have the states IDLE, ISSUE and HOLD.
REQ-007 In IDLE, the block SHALL select one source in this priority order:
- pending mute sequence;
- lock owner, if a lock is active;
- CPU FIFO, if not empty;
- sequencer, if seq_valid.
The selected byte SHALL be latched and the FSM SHALL go to ISSUE on the next cycle. With no source selected, the FSM SHALL stay in IDLE.
REQ-008 seq_ready SHALL be combinational and SHALL be high only in IDLE when the sequencer is the selected source. The transfer SHALL occur when seq_valid and seq_ready are both high. A CPU FIFO pop SHALL occur in the same selecting cycle.
REQ-009 ISSUE SHALL last exactly 1 cycle.
- In ISSUE, psg_ce=psg_we=1 and psg_data=latched byte; at all other times psg_ce=psg_we=0 and psg_data holds its last value.
- After ISSUE, the FSM SHALL go to HOLD.
REQ-010 HOLD SHALL last exactly HOLD_CYC cycles, using an 8-bit down-counter, and SHALL then go to IDLE.
- Spacing between psg_ce pulses SHALL therefore be at least HOLD_CYC+2 cycles.
REQ-011 A lock SHALL be set when an issued byte from the CPU or sequencer has bit7=1 and bits[6:4] in {0,2,4} (tone frequency latch).
- The lock owner SHALL be that source.
- While locked, the other source SHALL NOT be granted.
REQ-012 The lock SHALL clear when the owner's next byte is issued, and that byte SHALL re-evaluate REQ-011. The lock SHALL also clear when LOCK_TO cycles elapse in IDLE with no owner byte available (timeout counter counts IDLE cycles only).
REQ-013 mute_req SHALL be edge-detected with a registered previous value.
- On a rising edge, a mute sequence SHALL become pending.
- The sequence SHALL issue 0x9F, 0xBF, 0xDF, 0xFF in order, each a separate ISSUE/HOLD.
- The sequence SHALL override and clear any lock.
- A rising edge during an active sequence SHALL be ignored.
- Mute bytes SHALL NOT set a lock.
REQ-014 busy SHALL be asserted when the FSM is in ISSUE or HOLD.
REQ-015 A cpu_we in the same cycle as a FIFO pop SHALL cause the count to stay the same when the FIFO was not full. FIFO pointers SHALL be 2 bits and SHALL wrap modulo 4.

Reset
REQ-016 While reset_n=0 at a clk edge, all of the following SHALL hold:
- FSM=IDLE;
- FIFO empty, count=0;
- cpu_full=0, cpu_ovf=0;
- lock cleared;
- mute pending cleared, edge register=0;
- counters=0;
- psg_ce=0, psg_we=0, psg_data=0x00, busy=0, seq_ready=0.
REQ-017 Reset asserted mid-ISSUE or mid-HOLD SHALL abort the write, discard FIFO contents and discard any partial mute sequence.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Single CPU write: cpu_we with 0x90, HOLD_CYC=32 -> psg_ce pulse with 0x90 two cycles later; busy for 33 cycles.
- Priority: CPU FIFO holds 0x91 and seq_valid presents 0xB2 at the same time -> 0x91 issued first, 0xB2 after HOLD, seq_ready high for exactly 1 cycle.
- Lock: seq issues 0x85; CPU then pushes 0x93; seq presents 0x12 after 10 cycles -> order 0x85, 0x12, 0x93.
- Lock timeout: seq issues 0x85 and never follows, LOCK_TO=64, CPU pending 0x93 -> 0x93 issued 64 IDLE cycles after HOLD ends.
- Overflow: five back-to-back cpu_we while HOLD is active -> cpu_full=1 after the 4th; 5th dropped, cpu_ovf=1.
- Mute: rising edge of mute_req during a seq lock -> 0x9F, 0xBF, 0xDF, 0xFF issued consecutively, lock cleared; reset_n=0 after the second byte -> no further writes, all outputs at reset values.

Source files
------------

// File: rtl/psg_write_sched_if.sv
// Bus bundle for psg_write_sched: CPU write port, sequencer handshake, mute request
// and the PSG write side.
interface psg_write_sched_if;
    logic       cpu_we;
    logic [7:0] cpu_data;
    logic       cpu_full;
    logic       cpu_ovf;
    logic       seq_valid;
    logic [7:0] seq_data;
    logic       seq_ready;
    logic       mute_req;
    logic       psg_ce;
    logic       psg_we;
    logic [7:0] psg_data;
    logic       busy;

    modport master (
        output cpu_we, cpu_data, seq_valid, seq_data, mute_req,
        input  cpu_full, cpu_ovf, seq_ready, psg_ce, psg_we, psg_data, busy
    );

    modport slave (
        input  cpu_we, cpu_data, seq_valid, seq_data, mute_req,
        output cpu_full, cpu_ovf, seq_ready, psg_ce, psg_we, psg_data, busy
    );
endinterface

// File: rtl/psg_write_sched.sv
// PSG write scheduler: arbitrates mute sequence, CPU FIFO and sequencer bytes into
// single-cycle PSG writes, each followed by a fixed hold time.
module psg_write_sched #(
    parameter int unsigned HOLD_CYC = 32,
    parameter int unsigned LOCK_TO  = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    psg_write_sched_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;
    typedef enum logic [1:0] {SrcNone, SrcMute, SrcCpu, SrcSeq} src_e;

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYC);
    localparam logic [7:0] LockLast = 8'(LOCK_TO - 1);

    state_e     state_q, state_d;
    src_e       src_q, src_d, sel;
    logic [7:0] fifo_q [4];
    logic [7:0] fifo_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       full_q, full_d, ovf_q, ovf_d;
    logic [7:0] data_q, data_d;
    logic       lock_q, lock_d, lock_seq_q, lock_seq_d;
    logic [7:0] lock_cnt_q, lock_cnt_d, hold_cnt_q, hold_cnt_d;
    logic       mute_prev_q, mute_prev_d, mute_pend_q, mute_pend_d;
    logic [2:0] mute_idx_q, mute_idx_d;
    logic       push, pop, owner_avail, lock_expire, lock_eff, mute_sel;

    // Tone frequency latch bytes for channels 0..2 start a two-byte pair.
    function automatic logic is_freq(input logic [7:0] b);
        return b[7] && (b[6:4] == 3'd0 || b[6:4] == 3'd2 || b[6:4] == 3'd4);
    endfunction

    always_comb begin
        push        = bus.cpu_we && !full_q;
        owner_avail = lock_seq_q ? bus.seq_valid : (count_q != 3'd0);
        lock_expire = lock_q && !owner_avail && (lock_cnt_q == LockLast);
        lock_eff    = lock_q && !lock_expire;
        mute_sel    = mute_pend_q && (mute_idx_q != 3'd4);

        sel = SrcNone;
        if (state_q == StIdle) begin
            if (mute_sel) begin
                sel = SrcMute;
            end else if (lock_eff) begin
                if (owner_avail) sel = lock_seq_q ? SrcSeq : SrcCpu;
            end else if (count_q != 3'd0) begin
                sel = SrcCpu;
            end else if (bus.seq_valid) begin
                sel = SrcSeq;
            end
        end
        pop = (sel == SrcCpu);
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        data_d      = data_q;
        lock_d      = lock_q;
        lock_seq_d  = lock_seq_q;
        lock_cnt_d  = lock_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        mute_pend_d = mute_pend_q;
        mute_idx_d  = mute_idx_q;
        mute_prev_d = bus.mute_req;

        // Full is judged on the registered count, so a pop cannot make room same-cycle.
        if (push) begin
            fifo_d[wr_ptr_q] = bus.cpu_data;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        full_d  = (count_d == 3'd4);
        ovf_d   = ovf_q | (bus.cpu_we & full_q);

        if (bus.mute_req && !mute_prev_q && !mute_pend_q) mute_pend_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (lock_expire) begin
                    lock_d     = 1'b0;
                    lock_cnt_d = 8'd0;
                end else if (lock_q && sel == SrcNone) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
                if (sel != SrcNone) begin
                    state_d = StIssue;
                    src_d   = sel;
                end
                unique case (sel)
                    SrcMute: begin
                        data_d     = {1'b1, mute_idx_q[1:0], 5'h1f};
                        mute_idx_d = mute_idx_q + 3'd1;
                        lock_d     = 1'b0;
                        lock_cnt_d = 8'd0;
                    end
                    SrcCpu:  data_d = fifo_q[rd_ptr_q];
                    SrcSeq:  data_d = bus.seq_data;
                    default: ;
                endcase
            end
            StIssue: begin
                state_d    = StHold;
                hold_cnt_d = HoldLoad;
                lock_cnt_d = 8'd0;
                // Every non-mute issue re-evaluates the lock from scratch.
                lock_d     = (src_q != SrcMute) && is_freq(data_q);
                lock_seq_d = (src_q == SrcSeq);
            end
            StHold: begin
                hold_cnt_d = hold_cnt_q - 8'd1;
                if (hold_cnt_q <= 8'd1) begin
                    state_d = StIdle;
                    if (mute_pend_q && mute_idx_q == 3'd4) begin
                        mute_pend_d = 1'b0;
                        mute_idx_d  = 3'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            src_q       <= SrcNone;
            fifo_q      <= '{default: 8'h00};
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            data_q      <= 8'h00;
            lock_q      <= 1'b0;
            lock_seq_q  <= 1'b0;
            lock_cnt_q  <= 8'd0;
            hold_cnt_q  <= 8'd0;
            mute_prev_q <= 1'b0;
            mute_pend_q <= 1'b0;
            mute_idx_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            data_q      <= data_d;
            lock_q      <= lock_d;
            lock_seq_q  <= lock_seq_d;
            lock_cnt_q  <= lock_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            mute_prev_q <= mute_prev_d;
            mute_pend_q <= mute_pend_d;
            mute_idx_q  <= mute_idx_d;
        end
    end

    assign bus.psg_ce    = (state_q == StIssue);
    assign bus.psg_we    = (state_q == StIssue);
    assign bus.psg_data  = data_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.cpu_full  = full_q;
    assign bus.cpu_ovf   = ovf_q;
    // Gated so seq_ready stays low for the whole reset window.
    assign bus.seq_ready = reset_n && (sel == SrcSeq);

endmodule

// File: tb/tb_psg_write_sched.sv
// Directed bench for psg_write_sched: write timing, priority, lock, timeout,
// overflow, mute sequence and reset abort.
module tb_psg_write_sched;
    localparam int HoldCyc = 32;
    localparam int LockTo  = 64;
    localparam int Gap     = HoldCyc + 2;

    logic clk = 1'b0;
    logic reset_n;

    psg_write_sched_if bus ();

    psg_write_sched #(
        .HOLD_CYC(HoldCyc),
        .LOCK_TO (LockTo)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wr_data [$];
    int         wr_cyc  [$];
    int         busy_cnt = 0;
    int         rdy_cnt  = 0;
    int         we_bad   = 0;

    always @(negedge clk) begin
        if (bus.psg_ce) begin
            wr_data.push_back(bus.psg_data);
            wr_cyc.push_back(cyc);
        end
        if (bus.psg_ce !== bus.psg_we) we_bad = we_bad + 1;
        if (bus.busy) busy_cnt = busy_cnt + 1;
        if (bus.seq_ready) rdy_cnt = rdy_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] b);
        bus.cpu_we   = 1'b1;
        bus.cpu_data = b;
        tick(1);
        bus.cpu_we   = 1'b0;
    endtask

    task automatic seq_send(input string tag, input logic [7:0] b);
        bit done = 1'b0;
        bus.seq_valid = 1'b1;
        bus.seq_data  = b;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (bus.seq_ready) done = 1'b1;
            tick(1);
        end
        bus.seq_valid = 1'b0;
        check_eq({tag, "_seq_hs"}, 32'(done), 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int base, input int n, input int budget);
        int k = 0;
        while (wr_data.size() < base + n && k < budget) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_wr_count"}, 32'(wr_data.size() - base), 32'(n));
    endtask

    task automatic reset_check(input string tag);
        check_eq({tag, "_psg_ce"},    32'(bus.psg_ce),    32'd0);
        check_eq({tag, "_psg_we"},    32'(bus.psg_we),    32'd0);
        check_eq({tag, "_psg_data"},  32'(bus.psg_data),  32'h00);
        check_eq({tag, "_busy"},      32'(bus.busy),      32'd0);
        check_eq({tag, "_seq_ready"}, 32'(bus.seq_ready), 32'd0);
        check_eq({tag, "_cpu_full"},  32'(bus.cpu_full),  32'd0);
        check_eq({tag, "_cpu_ovf"},   32'(bus.cpu_ovf),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b, bz, br, k, t;
        reset_n       = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_data  = 8'h00;
        bus.seq_valid = 1'b1;
        bus.seq_data  = 8'h55;
        bus.mute_req  = 1'b0;
        tick(3);
        reset_check("rst0");
        bus.seq_valid = 1'b0;
        reset_n       = 1'b1;
        tick(2);

        // Single CPU write: pulse two cycles after the strobe, busy for HOLD_CYC+1.
        b = wr_data.size(); bz = busy_cnt; k = cyc;
        cpu_write(8'h90);
        wait_writes("single", b, 1, 10);
        check_eq("single_data", 32'(wr_data[b]), 32'h90);
        check_eq("single_cyc", 32'(wr_cyc[b]), 32'(k + 2));
        tick(40);
        check_eq("single_busy_len", 32'(busy_cnt - bz), 32'(HoldCyc + 1));
        check_eq("single_ce_low", 32'(bus.psg_ce), 32'd0);
        check_eq("single_data_hold", 32'(bus.psg_data), 32'h90);

        // Priority: CPU before sequencer, seq_ready for exactly one cycle.
        b = wr_data.size(); br = rdy_cnt;
        cpu_write(8'h91);
        seq_send("prio", 8'hb2);
        wait_writes("prio", b, 2, 3 * Gap);
        check_eq("prio_first", 32'(wr_data[b]), 32'h91);
        check_eq("prio_second", 32'(wr_data[b + 1]), 32'hb2);
        check_eq("prio_gap", 32'(wr_cyc[b + 1] - wr_cyc[b]), 32'(Gap));
        check_eq("prio_ready_len", 32'(rdy_cnt - br), 32'd1);
        tick(40);

        // Lock: sequencer owns the pair, CPU waits behind it.
        b = wr_data.size();
        seq_send("lock_a", 8'h85);
        cpu_write(8'h93);
        tick(10);
        seq_send("lock_b", 8'h12);
        wait_writes("lock", b, 3, 4 * Gap);
        check_eq("lock_b0", 32'(wr_data[b]), 32'h85);
        check_eq("lock_b1", 32'(wr_data[b + 1]), 32'h12);
        check_eq("lock_b2", 32'(wr_data[b + 2]), 32'h93);
        check_eq("lock_gap", 32'(wr_cyc[b + 1] - wr_cyc[b]), 32'(Gap));
        tick(40);

        // Lock timeout: CPU byte goes out after LOCK_TO idle cycles.
        b = wr_data.size();
        seq_send("tmo", 8'h85);
        cpu_write(8'h93);
        wait_writes("tmo", b, 2, 250);
        check_eq("tmo_b1", 32'(wr_data[b + 1]), 32'h93);
        check_eq("tmo_gap", 32'(wr_cyc[b + 1] - wr_cyc[b]), 32'(HoldCyc + 1 + LockTo));
        tick(40);

        // Overflow: five strobes during HOLD, fifth dropped.
        b = wr_data.size();
        cpu_write(8'h9a);
        tick(3);
        for (int i = 1; i <= 5; i++) begin
            bus.cpu_we   = 1'b1;
            bus.cpu_data = 8'(i);
            tick(1);
            if (i == 3) check_eq("ovf_full3", 32'(bus.cpu_full), 32'd0);
            if (i == 4) begin
                check_eq("ovf_full4", 32'(bus.cpu_full), 32'd1);
                check_eq("ovf_flag4", 32'(bus.cpu_ovf), 32'd0);
            end
        end
        bus.cpu_we = 1'b0;
        check_eq("ovf_full5", 32'(bus.cpu_full), 32'd1);
        check_eq("ovf_flag5", 32'(bus.cpu_ovf), 32'd1);
        wait_writes("ovf", b, 5, 6 * Gap);
        tick(Gap + 10);
        check_eq("ovf_total", 32'(wr_data.size() - b), 32'd5);
        for (int i = 1; i <= 4; i++) check_eq("ovf_byte", 32'(wr_data[b + i]), 32'(i));
        check_eq("ovf_sticky", 32'(bus.cpu_ovf), 32'd1);
        check_eq("ovf_not_full", 32'(bus.cpu_full), 32'd0);

        // Mute during a sequencer lock; a second edge mid-sequence is ignored.
        b = wr_data.size();
        seq_send("mute", 8'h85);
        tick(5);
        bus.mute_req = 1'b1;
        wait_writes("mute_part", b, 3, 4 * Gap);
        bus.mute_req = 1'b0;
        tick(2);
        bus.mute_req = 1'b1;
        wait_writes("mute", b, 5, 4 * Gap);
        tick(Gap + 10);
        check_eq("mute_total", 32'(wr_data.size() - b), 32'd5);
        for (int i = 0; i < 4; i++) begin
            check_eq("mute_byte", 32'(wr_data[b + 1 + i]), 32'(8'h9f + 8'(i * 32)));
            check_eq("mute_gap", 32'(wr_cyc[b + 1 + i] - wr_cyc[b + i]), 32'(Gap));
        end
        b = wr_data.size(); k = cyc;
        cpu_write(8'h93);
        wait_writes("unlock", b, 1, 10);
        check_eq("unlock_data", 32'(wr_data[b]), 32'h93);
        check_eq("unlock_cyc", 32'(wr_cyc[b]), 32'(k + 2));
        tick(40);

        // Reset after the second mute byte aborts the rest.
        bus.mute_req = 1'b0;
        tick(2);
        bus.mute_req = 1'b1;
        b = wr_data.size();
        wait_writes("mrst", b, 2, 3 * Gap);
        check_eq("mrst_b0", 32'(wr_data[b]), 32'h9f);
        check_eq("mrst_b1", 32'(wr_data[b + 1]), 32'hbf);
        tick(3);
        bus.mute_req  = 1'b0;
        reset_n       = 1'b0;
        bus.seq_valid = 1'b1;
        tick(2);
        reset_check("mrst");
        bus.seq_valid = 1'b0;
        reset_n       = 1'b1;
        t = wr_data.size();
        tick(200);
        check_eq("mrst_no_writes", 32'(wr_data.size() - t), 32'd0);
        check_eq("mrst_busy", 32'(bus.busy), 32'd0);

        check_eq("ce_we_equal", 32'(we_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
